// File: rtl/afifo_pkg.sv
// Constants shared between afifo and its read-side stream adapter.
package afifo_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int CNT_W_DEF  = 16;

    // Read-side buffer: two entries is the minimum for 1 word/cycle with a
    // registered afifo read port.
    localparam int SKID_DEPTH = 2;
    localparam int OCC_W      = 2;

    // Occupancy after one cycle of push/pop, one bit wider so the caller can
    // compare against SKID_DEPTH without wrap.
    function automatic logic [OCC_W:0] occ_next(input logic [OCC_W-1:0] occ,
                                                 input logic             push,
                                                 input logic             pop);
        logic [OCC_W:0] ext;
        ext = {1'b0, occ};
        return ext + {{OCC_W{1'b0}}, push} - {{OCC_W{1'b0}}, pop};
    endfunction

endpackage

// File: rtl/afifo_skid2.sv
// Two-entry ordered buffer: entry 0 is the head, new words land at the tail
// index after any same-cycle pop has shifted entry 1 down.
module afifo_skid2
    import afifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              rclk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [OCC_W-1:0]  occ,
    output logic [DATA_W-1:0] head
);

    logic [SKID_DEPTH-1:0][DATA_W-1:0] ent;
    logic [SKID_DEPTH-1:0][DATA_W-1:0] ent_n;
    logic [OCC_W-1:0]                  tail;
    logic [OCC_W:0]                    lvl;

    assign head = ent[0];

    // Next entry contents: shift on pop, then write the incoming word at the tail.
    always_comb begin
        ent_n = ent;
        tail  = occ - {{(OCC_W-1){1'b0}}, pop};
        lvl   = occ_next(occ, push, pop);
        if (pop) begin
            ent_n[0] = ent[1];
        end
        if (push) begin
            if (tail == '0) begin
                ent_n[0] = din;
            end else begin
                ent_n[1] = din;
            end
        end
    end

    // Entry and occupancy registers.
    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            ent <= '0;
            occ <= '0;
        end else begin
            ent <= ent_n;
            occ <= lvl[OCC_W-1:0];
        end
    end

endmodule

// File: rtl/afifo_rd_stream.sv
// afifo read-port consumer: issues reads from the empty flag, tracks the one
// word in flight, and re-presents data as a first-word-fall-through stream.
module afifo_rd_stream
    import afifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              rclk,
    input  logic              rst,
    input  logic              fifo_empty,
    output logic              fifo_ren,
    input  logic [DATA_W-1:0] fifo_out,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [CNT_W-1:0]  m_count,
    output logic              busy
);

    localparam logic [OCC_W:0] DEPTH_L = (OCC_W+1)'(SKID_DEPTH);

    logic             pend;
    logic             pop;
    logic [OCC_W-1:0] occ;
    logic [OCC_W:0]   lvl;

    assign pop     = m_valid & m_ready;
    assign m_valid = (occ != '0);
    assign busy    = pend | m_valid;

    // Counting the in-flight word and this cycle's pop keeps streaming at one
    // word per cycle while never issuing a read the buffer could not hold.
    assign lvl      = occ_next(occ, pend, pop);
    assign fifo_ren = !rst & !fifo_empty & (lvl < DEPTH_L);

    // A read issued this edge returns data next cycle; that is the only source of pushes.
    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            pend <= 1'b0;
        end else begin
            pend <= fifo_ren;
        end
    end

    // Words handed downstream, wrapping naturally.
    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            m_count <= '0;
        end else if (pop) begin
            m_count <= m_count + CNT_W'(1);
        end
    end

    afifo_skid2 #(
        .DATA_W (DATA_W)
    ) u_buf (
        .rclk (rclk),
        .rst  (rst),
        .push (pend),
        .din  (fifo_out),
        .pop  (pop),
        .occ  (occ),
        .head (m_data)
    );

endmodule
